// File: rtl/dmem_pkg.sv
// Shared constants for the block data-memory responder: FSM encoding,
// latency-counter width and the default data-cache geometry.
package dmem_pkg;

    localparam int DMEM_BLOCK_ADDR_SIZE = 6;
    localparam int DMEM_BLOCK_SIZE_BITS = 128;
    localparam int DMEM_CNT_WIDTH       = 4;

    localparam logic [DMEM_CNT_WIDTH-1:0] DMEM_CNT_ZERO = 4'd0;
    localparam logic [DMEM_CNT_WIDTH-1:0] DMEM_CNT_ONE  = 4'd1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_WAIT = 3'd1;
    localparam logic [2:0] ST_WR_WAIT = 3'd2;
    localparam logic [2:0] ST_RD_DONE = 3'd3;
    localparam logic [2:0] ST_WR_DONE = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;

    // The wait state lasts latency-1 decrements plus the edge that leaves it.
    function automatic logic [DMEM_CNT_WIDTH-1:0] latencyToLoad(input int unsigned latency);
        return DMEM_CNT_WIDTH'(latency - 32'd1);
    endfunction

endpackage

// File: rtl/dmem_latency_counter.sv
// Loadable down-counter shared by the read and write wait states; it stops at zero.
module dmem_latency_counter
    import dmem_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      enable,
    input  logic [DMEM_CNT_WIDTH-1:0] loadValue,
    output logic                      isZero
);

    logic [DMEM_CNT_WIDTH-1:0] count_r;

    // Load has priority over counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= DMEM_CNT_ZERO;
        end else if (load) begin
            count_r <= loadValue;
        end else if (enable && (count_r != DMEM_CNT_ZERO)) begin
            count_r <= count_r - DMEM_CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign isZero = (count_r == DMEM_CNT_ZERO);

endmodule

// File: rtl/dmem_block_responder.sv
// Block-granular memory responder for the L1 D-cache miss interface with fixed
// read/write latencies. Define DMEM_PROTOCOL_CHECK_EN to add the protocolError checker.
module dmem_block_responder
    import dmem_pkg::*;
#(
    parameter int BLOCK_ADDR_SIZE = DMEM_BLOCK_ADDR_SIZE,
    parameter int BLOCK_SIZE_BITS = DMEM_BLOCK_SIZE_BITS,
    parameter int READ_LATENCY    = 4,
    parameter int WRITE_LATENCY   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       memRen,
    input  logic                       memWen,
    input  logic [BLOCK_ADDR_SIZE-1:0] BlockAddr,
    input  logic [BLOCK_SIZE_BITS-1:0] memDin,
    output logic [BLOCK_SIZE_BITS-1:0] memDout,
    output logic                       memReadReady,
    output logic                       memWriteDone
`ifdef DMEM_PROTOCOL_CHECK_EN
    ,
    output logic                       protocolError
`endif
);

    localparam logic [DMEM_CNT_WIDTH-1:0] RD_LOAD = latencyToLoad(READ_LATENCY);
    localparam logic [DMEM_CNT_WIDTH-1:0] WR_LOAD = latencyToLoad(WRITE_LATENCY);

    logic [BLOCK_SIZE_BITS-1:0] mem_r [0:(2**BLOCK_ADDR_SIZE)-1];

    logic [2:0]                 state_r;
    logic [2:0]                 nextState_s;
    logic [BLOCK_ADDR_SIZE-1:0] addr_r;
    logic [BLOCK_SIZE_BITS-1:0] data_r;
    logic                       wasRead_r;
    logic                       acceptRead_s;
    logic                       acceptWrite_s;
    logic                       cntLoad_s;
    logic                       cntEnable_s;
    logic [DMEM_CNT_WIDTH-1:0]  cntLoadValue_s;
    logic                       cntZero_s;
    logic                       inWait_s;

    assign acceptRead_s   = (state_r == ST_IDLE) && memRen && !memWen;
    assign acceptWrite_s  = (state_r == ST_IDLE) && memWen && !memRen;
    assign inWait_s       = (state_r == ST_RD_WAIT) || (state_r == ST_WR_WAIT);
    assign cntLoad_s      = acceptRead_s || acceptWrite_s;
    assign cntEnable_s    = inWait_s;
    assign cntLoadValue_s = acceptRead_s ? RD_LOAD : WR_LOAD;

    dmem_latency_counter u_latencyCounter (
        .clock     (clock),
        .reset     (reset),
        .load      (cntLoad_s),
        .enable    (cntEnable_s),
        .loadValue (cntLoadValue_s),
        .isZero    (cntZero_s)
    );

    // Next-state logic; RELEASE waits for the completed request type to drop.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (acceptRead_s) begin
                    nextState_s = ST_RD_WAIT;
                end else if (acceptWrite_s) begin
                    nextState_s = ST_WR_WAIT;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (cntZero_s) begin
                    nextState_s = ST_RD_DONE;
                end else begin
                    nextState_s = ST_RD_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (cntZero_s) begin
                    nextState_s = ST_WR_DONE;
                end else begin
                    nextState_s = ST_WR_WAIT;
                end
            end
            ST_RD_DONE: nextState_s = ST_RELEASE;
            ST_WR_DONE: nextState_s = ST_RELEASE;
            ST_RELEASE: begin
                if (wasRead_r ? !memRen : !memWen) begin
                    nextState_s = ST_IDLE;
                end else begin
                    nextState_s = ST_RELEASE;
                end
            end
            default: nextState_s = ST_IDLE;
        endcase
    end

    // FSM state, request latches and registered completion outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            addr_r       <= {BLOCK_ADDR_SIZE{1'b0}};
            data_r       <= {BLOCK_SIZE_BITS{1'b0}};
            wasRead_r    <= 1'b0;
            memDout      <= {BLOCK_SIZE_BITS{1'b0}};
            memReadReady <= 1'b0;
            memWriteDone <= 1'b0;
        end else begin
            state_r      <= nextState_s;
            memReadReady <= (state_r == ST_RD_WAIT) && (nextState_s == ST_RD_DONE);
            memWriteDone <= (state_r == ST_WR_WAIT) && (nextState_s == ST_WR_DONE);
            if (acceptRead_s) begin
                addr_r    <= BlockAddr;
                wasRead_r <= 1'b1;
            end else if (acceptWrite_s) begin
                addr_r    <= BlockAddr;
                data_r    <= memDin;
                wasRead_r <= 1'b0;
            end else begin
                addr_r    <= addr_r;
                wasRead_r <= wasRead_r;
            end
            if ((state_r == ST_RD_WAIT) && (nextState_s == ST_RD_DONE)) begin
                memDout <= mem_r[addr_r];
            end else begin
                memDout <= memDout;
            end
        end
    end

    // Storage is not reset; a write commits only on the edge entering WR_DONE.
    always_ff @(posedge clock) begin
        if (!reset && (state_r == ST_WR_WAIT) && cntZero_s) begin
            mem_r[addr_r] <= data_r;
        end
    end

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic violation_s;

    assign violation_s = (memRen && memWen)
                       || ((state_r == ST_RD_WAIT) && !memRen)
                       || ((state_r == ST_WR_WAIT) && !memWen)
                       || (inWait_s && (BlockAddr != addr_r));

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            protocolError <= 1'b0;
        end else if (violation_s) begin
            protocolError <= 1'b1;
        end else begin
            protocolError <= protocolError;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_block_responder.sv
// Scoreboard bench for dmem_block_responder: latency, data, pulse count, reset abort.
module tb_dmem_block_responder;

    localparam int AW = 6;
    localparam int BW = 128;
    localparam int RL = 4;
    localparam int WL = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          memRen;
    logic          memWen;
    logic [AW-1:0] BlockAddr;
    logic [BW-1:0] memDin;
    logic [BW-1:0] memDout;
    logic          memReadReady;
    logic          memWriteDone;
`ifdef DMEM_PROTOCOL_CHECK_EN
    logic          protocolError;
`endif

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] model [0:63];
    logic [BW-1:0] expQ [$];

    localparam logic [BW-1:0] D5   = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [BW-1:0] DEAD = 128'hDEADBEEF_01234567_89ABCDEF_00000001;
    localparam logic [BW-1:0] D7   = 128'h11112222_33334444_55556666_77778888;
    localparam logic [BW-1:0] DNEW = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;

    always #5 clock = ~clock;

    dmem_block_responder #(
        .BLOCK_ADDR_SIZE (AW),
        .BLOCK_SIZE_BITS (BW),
        .READ_LATENCY    (RL),
        .WRITE_LATENCY   (WL)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .memRen       (memRen),
        .memWen       (memWen),
        .BlockAddr    (BlockAddr),
        .memDin       (memDin),
        .memDout      (memDout),
        .memReadReady (memReadReady),
        .memWriteDone (memWriteDone)
`ifdef DMEM_PROTOCOL_CHECK_EN
        ,
        .protocolError (protocolError)
`endif
    );

    // Issues a read, pushes the model value, reports latency, data and pulse count.
    task automatic issueRead(input logic [AW-1:0] a, input int extraHold,
                             output int lat, output logic [BW-1:0] data, output int pulses);
        @(negedge clock);
        BlockAddr = a;
        memRen    = 1'b1;
        expQ.push_back(model[a]);
        lat = -1; data = '0; pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (memReadReady === 1'b1) begin
                lat = c; data = memDout; pulses = 1;
                break;
            end
        end
        for (int i = 0; i < extraHold; i++) begin
            @(posedge clock); #1;
            if (memReadReady === 1'b1) pulses++;
        end
        @(negedge clock);
        memRen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (memReadReady === 1'b1) pulses++;
        end
    endtask

    task automatic issueWrite(input logic [AW-1:0] a, input logic [BW-1:0] d,
                              output int lat, output int pulses);
        @(negedge clock);
        BlockAddr = a;
        memDin    = d;
        memWen    = 1'b1;
        lat = -1; pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (memWriteDone === 1'b1) begin
                lat = c; pulses = 1; model[a] = d;
                break;
            end
        end
        @(negedge clock);
        memWen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (memWriteDone === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (memReadReady !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0", memReadReady); end
        total++; if (memWriteDone !== 1'b0) begin bad++; $display("FAIL reset_wdone: got %b want 0", memWriteDone); end
        total++; if (memDout !== '0) begin bad++; $display("FAIL reset_dout: got %h want 0", memDout); end
`ifdef DMEM_PROTOCOL_CHECK_EN
        total++; if (protocolError !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", protocolError); end
`endif
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_read_write;
        int lat, pulses;
        logic [BW-1:0] data, exp;
        issueWrite(6'd5, D5, lat, pulses);
        total++; if (lat !== WL) begin bad++; $display("FAIL wr5_latency: got %0d want %0d", lat, WL); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL wr5_pulses: got %0d want 1", pulses); end
        issueRead(6'd5, 0, lat, data, pulses);
        exp = expQ.pop_front();
        total++; if (lat !== RL) begin bad++; $display("FAIL rd5_latency: got %0d want %0d", lat, RL); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL rd5_pulses: got %0d want 1", pulses); end
        total++; if (data !== exp) begin bad++; $display("FAIL rd5_data: got %h want %h", data, exp); end
        issueWrite(6'd3, DEAD, lat, pulses);
        total++; if (lat !== WL) begin bad++; $display("FAIL wr3_latency: got %0d want %0d", lat, WL); end
        issueRead(6'd3, 0, lat, data, pulses);
        exp = expQ.pop_front();
        total++; if (data !== exp) begin bad++; $display("FAIL rd3_data: got %h want %h", data, exp); end
        total++; if (data !== DEAD) begin bad++; $display("FAIL rd3_const: got %h want %h", data, DEAD); end
    endtask

    task automatic test_hold_extra;
        int lat, pulses;
        logic [BW-1:0] data, exp;
        issueRead(6'd5, 2, lat, data, pulses);
        exp = expQ.pop_front();
        total++; if (pulses !== 1) begin bad++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
        total++; if (lat !== RL) begin bad++; $display("FAIL hold_latency: got %0d want %0d", lat, RL); end
        total++; if (data !== exp) begin bad++; $display("FAIL hold_data: got %h want %h", data, exp); end
    endtask

    task automatic test_back_to_back;
        int wlat, gap;
        logic [BW-1:0] data, exp;
        @(negedge clock);
        BlockAddr = 6'd7; memDin = D7; memWen = 1'b1;
        wlat = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (memWriteDone === 1'b1) begin wlat = c; break; end
        end
        total++; if (wlat !== WL) begin bad++; $display("FAIL b2b_wr_latency: got %0d want %0d", wlat, WL); end
        @(negedge clock);
        model[7] = D7;
        memWen = 1'b0; memRen = 1'b1;
        expQ.push_back(model[7]);
        gap = -1; data = '0;
        for (int c = 1; c < 40; c++) begin
            @(posedge clock); #1;
            if (memReadReady === 1'b1) begin gap = c; data = memDout; break; end
        end
        exp = expQ.pop_front();
        total++; if (gap !== 3 + RL) begin bad++; $display("FAIL b2b_gap: got %0d want %0d", gap, 3 + RL); end
        total++; if (data !== exp) begin bad++; $display("FAIL b2b_data: got %h want %h", data, exp); end
        @(negedge clock);
        memRen = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        total++; if (memDout !== D7) begin bad++; $display("FAIL dout_hold: got %h want %h", memDout, D7); end
    endtask

    task automatic test_reset_midwrite;
        int lat, pulses;
        logic [BW-1:0] data, exp;
        @(negedge clock);
        BlockAddr = 6'd3; memDin = DNEW; memWen = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1; memWen = 1'b0;
        @(posedge clock); #1;
        total++; if (memDout !== '0) begin bad++; $display("FAIL midrst_dout: got %h want 0", memDout); end
        total++; if (memWriteDone !== 1'b0) begin bad++; $display("FAIL midrst_wdone: got %b want 0", memWriteDone); end
        total++; if (memReadReady !== 1'b0) begin bad++; $display("FAIL midrst_rdy: got %b want 0", memReadReady); end
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(posedge clock); #1;
        total++; if (memWriteDone !== 1'b0) begin bad++; $display("FAIL midrst_late_wdone: got %b want 0", memWriteDone); end
        issueRead(6'd3, 0, lat, data, pulses);
        exp = expQ.pop_front();
        total++; if (data !== exp) begin bad++; $display("FAIL midrst_old_data: got %h want %h", data, exp); end
    endtask

    task automatic test_both_high;
        int cnt, lat, pulses;
        logic [BW-1:0] data, exp;
`ifdef DMEM_PROTOCOL_CHECK_EN
        total++; if (protocolError !== 1'b0) begin bad++; $display("FAIL perr_clean: got %b want 0", protocolError); end
`endif
        @(negedge clock);
        BlockAddr = 6'd5; memRen = 1'b1; memWen = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (memReadReady === 1'b1 || memWriteDone === 1'b1) cnt++;
        end
        total++; if (cnt !== 0) begin bad++; $display("FAIL both_no_txn: got %0d pulses want 0", cnt); end
        @(negedge clock);
        memRen = 1'b0; memWen = 1'b0;
        repeat (3) @(posedge clock); #1;
`ifdef DMEM_PROTOCOL_CHECK_EN
        total++; if (protocolError !== 1'b1) begin bad++; $display("FAIL perr_sticky: got %b want 1", protocolError); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        total++; if (protocolError !== 1'b0) begin bad++; $display("FAIL perr_cleared: got %b want 0", protocolError); end
        @(negedge clock);
        reset = 1'b0;
`endif
        issueRead(6'd5, 0, lat, data, pulses);
        exp = expQ.pop_front();
        total++; if (lat !== RL) begin bad++; $display("FAIL after_both_latency: got %0d want %0d", lat, RL); end
        total++; if (data !== exp) begin bad++; $display("FAIL after_both_data: got %h want %h", data, exp); end
    endtask

    initial begin
        reset = 1'b1; memRen = 1'b0; memWen = 1'b0;
        BlockAddr = '0; memDin = '0;
        for (int i = 0; i < 64; i++) model[i] = '0;
        test_reset();
        test_read_write();
        test_hold_extra();
        test_back_to_back();
        test_reset_midwrite();
        test_both_high();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
